// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit accumulator CPU control path.
// CONTROL_UNIT_HLT_EN adds the HALT state to the state enum.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH1,
    S_DECODE,
    S_FETCH2,
    S_MRD,
    S_MALU,
    S_SRD,
    S_SALU,
    S_SWR,
    S_JUMP,
    S_RRD_A,
    S_RRD_B,
    S_RALU,
    S_WB
`ifdef CONTROL_UNIT_HLT_EN
    , S_HALT
`endif
  } state_t;

  // Memory-reference sub-ops live in IR[6:5]; class codes in IR[7:6].
  localparam logic [1:0] MEM_LDM = 2'b00;
  localparam logic [1:0] MEM_STM = 2'b01;
  localparam logic [1:0] MEM_JMP = 2'b10;
  localparam logic [1:0] MEM_BZ  = 2'b11;
  localparam logic [1:0] CLS_REG = 2'b10;
  localparam logic [3:0] OPC_NOP = 4'b1100;
  localparam logic [3:0] OPC_HLT = 4'b1101;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_ADC  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  localparam logic [1:0] ACC_SEL_DI  = 2'b00;
  localparam logic [1:0] ACC_SEL_SRC = 2'b01;
  localparam logic [1:0] ACC_SEL_DST = 2'b10;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;

  typedef struct packed {
    logic       pc_inc;
    logic       pc_load_en;
    logic       di_load_en;
    logic       ir_write_en;
    logic       tr_write_en;
    logic       mem_read_en;
    logic       mem_write_en;
    logic       acc_write_en;
    logic       a_write_en;
    logic       b_write_en;
    logic       alu_res_write_en;
    logic       ld_czn;
    logic       pc_or_tr;
    logic       reg_or_mem;
    logic       reg_a_or_0;
    logic       reg_b_or_0;
    logic [1:0] acc_sel;
    logic [1:0] alu_op;
    logic       halted;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/control_decode.sv
// Pure Moore decode of FSM state plus latched opcode into datapath strobes.
// CONTROL_UNIT_HLT_EN enables the HALT state decode.
module control_decode
  import cpu_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      S_FETCH1: begin
        ctrl.pc_or_tr    = 1'b1;
        ctrl.mem_read_en = 1'b1;
        ctrl.ir_write_en = 1'b1;
        ctrl.pc_inc      = 1'b1;
      end
      S_DECODE: ctrl.di_load_en = 1'b1;
      S_FETCH2: begin
        ctrl.pc_or_tr    = 1'b1;
        ctrl.mem_read_en = 1'b1;
        ctrl.tr_write_en = 1'b1;
        ctrl.pc_inc      = 1'b1;
      end
      S_MRD: begin
        ctrl.mem_read_en = 1'b1;
        ctrl.b_write_en  = 1'b1;
      end
      S_MALU: begin
        ctrl.reg_a_or_0       = 1'b1;
        ctrl.alu_op           = ALU_ADD;
        ctrl.alu_res_write_en = 1'b1;
        ctrl.ld_czn           = 1'b1;
      end
      S_SRD: begin
        ctrl.acc_sel    = ACC_SEL_DI;
        ctrl.reg_or_mem = 1'b1;
        ctrl.b_write_en = 1'b1;
      end
      // Store passes the accumulator through 0+B without touching flags.
      S_SALU: begin
        ctrl.reg_a_or_0       = 1'b1;
        ctrl.alu_op           = ALU_ADD;
        ctrl.alu_res_write_en = 1'b1;
      end
      S_SWR:  ctrl.mem_write_en = 1'b1;
      S_JUMP: ctrl.pc_load_en   = 1'b1;
      S_RRD_A: begin
        ctrl.acc_sel    = ACC_SEL_DST;
        ctrl.a_write_en = 1'b1;
      end
      S_RRD_B: begin
        ctrl.acc_sel    = ACC_SEL_SRC;
        ctrl.reg_or_mem = 1'b1;
        ctrl.b_write_en = 1'b1;
      end
      S_RALU: begin
        ctrl.alu_op           = opcode[1:0];
        ctrl.alu_res_write_en = 1'b1;
        ctrl.ld_czn           = 1'b1;
      end
      S_WB: begin
        ctrl.acc_write_en = 1'b1;
        ctrl.acc_sel      = opcode[3] ? ACC_SEL_DST : ACC_SEL_DI;
      end
`ifdef CONTROL_UNIT_HLT_EN
      S_HALT: ctrl.halted = 1'b1;
`endif
      default: ctrl = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle control FSM for the accumulator CPU: state register, next-state
// logic and reset gating. CONTROL_UNIT_HLT_EN enables HLT and the halted output.
module control_unit
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] DiToCU,
  input  logic [3:0] IrToCU,
  input  logic [2:0] CznToCU,
  output logic       pcInc,
  output logic       pcLoadEn,
  output logic       diLoadEn,
  output logic       irWriteEn,
  output logic       trWriteEn,
  output logic       memoryReadEn,
  output logic       memoryWriteEn,
  output logic       accumulatorWriteEn,
  output logic       aRegWriteEn,
  output logic       bRegWriteEn,
  output logic       aluResWriteEn,
  output logic       ldCZN,
  output logic       PcOrTR,
  output logic       regOrMem,
  output logic       RegAOr0,
  output logic       RegBOr0,
  output logic [1:0] accAddressSel,
  output logic [1:0] aluOpControl,
  output logic       halted
);

  state_t state;
  state_t next_state;
  ctrl_t  ctrl_raw;
  ctrl_t  ctrl;

  control_decode u_decode (
    .state  (state),
    .opcode (IrToCU),
    .ctrl   (ctrl_raw)
  );

  // Reset is sampled synchronously, but strobes drop as soon as rst goes low
  // so an aborted instruction issues nothing further.
  assign ctrl = rst ? ctrl_raw : CTRL_IDLE;

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH1: next_state = S_DECODE;
      S_DECODE: begin
        if (!IrToCU[3])                    next_state = S_FETCH2;
        else if (IrToCU[3:2] == CLS_REG)   next_state = S_RRD_A;
`ifdef CONTROL_UNIT_HLT_EN
        else if (IrToCU == OPC_HLT)        next_state = S_HALT;
`endif
        else                               next_state = S_FETCH1;
      end
      S_FETCH2: begin
        case (IrToCU[2:1])
          MEM_LDM: next_state = S_MRD;
          MEM_STM: next_state = S_SRD;
          MEM_JMP: next_state = S_JUMP;
          default: next_state = CznToCU[FLAG_Z] ? S_JUMP : S_FETCH1;
        endcase
      end
      S_MRD:   next_state = S_MALU;
      S_MALU:  next_state = S_WB;
      S_SRD:   next_state = S_SALU;
      S_SALU:  next_state = S_SWR;
      S_SWR:   next_state = S_FETCH1;
      S_JUMP:  next_state = S_FETCH1;
      S_RRD_A: next_state = S_RRD_B;
      S_RRD_B: next_state = S_RALU;
      S_RALU:  next_state = S_WB;
      S_WB:    next_state = S_FETCH1;
      default: next_state = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_FETCH1;
    else      state <= next_state;
  end

  assign pcInc              = ctrl.pc_inc;
  assign pcLoadEn           = ctrl.pc_load_en;
  assign diLoadEn           = ctrl.di_load_en;
  assign irWriteEn          = ctrl.ir_write_en;
  assign trWriteEn          = ctrl.tr_write_en;
  assign memoryReadEn       = ctrl.mem_read_en;
  assign memoryWriteEn      = ctrl.mem_write_en;
  assign accumulatorWriteEn = ctrl.acc_write_en;
  assign aRegWriteEn        = ctrl.a_write_en;
  assign bRegWriteEn        = ctrl.b_write_en;
  assign aluResWriteEn      = ctrl.alu_res_write_en;
  assign ldCZN              = ctrl.ld_czn;
  assign PcOrTR             = ctrl.pc_or_tr;
  assign regOrMem           = ctrl.reg_or_mem;
  assign RegAOr0            = ctrl.reg_a_or_0;
  assign RegBOr0            = ctrl.reg_b_or_0;
  assign accAddressSel      = ctrl.acc_sel;
  assign aluOpControl       = ctrl.alu_op;

`ifdef CONTROL_UNIT_HLT_EN
  assign halted = ctrl.halted;
`else
  logic unused_halt;
  assign halted      = 1'b0;
  assign unused_halt = ctrl.halted;
`endif

  // DI is consumed by the datapath directly; only Z steers sequencing.
  logic unused_status;
  assign unused_status = ^{DiToCU, CznToCU[FLAG_C], CznToCU[FLAG_N]};

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: reset, per-instruction strobe
// sequences, cycle counts, mid-instruction reset and (if enabled) HLT.
module tb_control_unit;

  localparam int W = 21;

  localparam logic [W-1:0] B_PCINC  = 21'd1 << 0;
  localparam logic [W-1:0] B_PCLD   = 21'd1 << 1;
  localparam logic [W-1:0] B_DI     = 21'd1 << 2;
  localparam logic [W-1:0] B_IRW    = 21'd1 << 3;
  localparam logic [W-1:0] B_TRW    = 21'd1 << 4;
  localparam logic [W-1:0] B_MEMRD  = 21'd1 << 5;
  localparam logic [W-1:0] B_MEMWR  = 21'd1 << 6;
  localparam logic [W-1:0] B_ACCW   = 21'd1 << 7;
  localparam logic [W-1:0] B_AW     = 21'd1 << 8;
  localparam logic [W-1:0] B_BW     = 21'd1 << 9;
  localparam logic [W-1:0] B_ALUW   = 21'd1 << 10;
  localparam logic [W-1:0] B_LDCZN  = 21'd1 << 11;
  localparam logic [W-1:0] B_PCORTR = 21'd1 << 12;
  localparam logic [W-1:0] B_RORM   = 21'd1 << 13;
  localparam logic [W-1:0] B_AOR0   = 21'd1 << 14;
  localparam logic [W-1:0] A_SRC    = 21'd1 << 16;
  localparam logic [W-1:0] A_DST    = 21'd2 << 16;
  localparam logic [W-1:0] B_HALTED = 21'd1 << 20;

  localparam logic [W-1:0] W_F1 = B_PCORTR | B_MEMRD | B_IRW | B_PCINC;
  localparam logic [W-1:0] W_F2 = B_PCORTR | B_MEMRD | B_TRW | B_PCINC;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] DiToCU  = '0;
  logic [3:0] IrToCU  = '0;
  logic [2:0] CznToCU = '0;
  logic pcInc, pcLoadEn, diLoadEn, irWriteEn, trWriteEn, memoryReadEn, memoryWriteEn;
  logic accumulatorWriteEn, aRegWriteEn, bRegWriteEn, aluResWriteEn, ldCZN;
  logic PcOrTR, regOrMem, RegAOr0, RegBOr0, halted;
  logic [1:0] accAddressSel, aluOpControl;

  control_unit dut (
    .clk(clk), .rst(rst), .DiToCU(DiToCU), .IrToCU(IrToCU), .CznToCU(CznToCU),
    .pcInc(pcInc), .pcLoadEn(pcLoadEn), .diLoadEn(diLoadEn), .irWriteEn(irWriteEn),
    .trWriteEn(trWriteEn), .memoryReadEn(memoryReadEn), .memoryWriteEn(memoryWriteEn),
    .accumulatorWriteEn(accumulatorWriteEn), .aRegWriteEn(aRegWriteEn),
    .bRegWriteEn(bRegWriteEn), .aluResWriteEn(aluResWriteEn), .ldCZN(ldCZN),
    .PcOrTR(PcOrTR), .regOrMem(regOrMem), .RegAOr0(RegAOr0), .RegBOr0(RegBOr0),
    .accAddressSel(accAddressSel), .aluOpControl(aluOpControl), .halted(halted)
  );

  logic [W-1:0] obs;
  assign obs = {halted, aluOpControl, accAddressSel, RegBOr0, RegAOr0, regOrMem, PcOrTR,
                ldCZN, aluResWriteEn, bRegWriteEn, aRegWriteEn, accumulatorWriteEn,
                memoryWriteEn, memoryReadEn, trWriteEn, irWriteEn, diLoadEn, pcLoadEn, pcInc};

  // scoreboard
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %06h expected %06h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] op_bits(input logic [1:0] op);
    logic [W-1:0] r;
    r = '0;
    r[19:18] = op;
    return r;
  endfunction

  // Reference: per-instruction micro-op list derived from the ISA rules.
  task automatic model(input logic [7:0] ir, input logic z);
    exp_q.push_back(W_F1);
    exp_q.push_back(B_DI);
    if (!ir[7]) begin
      exp_q.push_back(W_F2);
      case (ir[6:5])
        2'b00: begin
          exp_q.push_back(B_MEMRD | B_BW);
          exp_q.push_back(B_AOR0 | B_ALUW | B_LDCZN);
          exp_q.push_back(B_ACCW);
        end
        2'b01: begin
          exp_q.push_back(B_RORM | B_BW);
          exp_q.push_back(B_AOR0 | B_ALUW);
          exp_q.push_back(B_MEMWR);
        end
        2'b10: exp_q.push_back(B_PCLD);
        default: if (z) exp_q.push_back(B_PCLD);
      endcase
    end else if (!ir[6]) begin
      exp_q.push_back(B_AW | A_DST);
      exp_q.push_back(A_SRC | B_RORM | B_BW);
      exp_q.push_back(op_bits(ir[5:4]) | B_ALUW | B_LDCZN);
      exp_q.push_back(B_ACCW | A_DST);
    end
  endtask

  // driver: called at posedge+1 while the DUT is in FETCH1
  task automatic drive(input logic [7:0] ir, input logic z);
    IrToCU  = ir[7:4];
    DiToCU  = ir[4:0];
    CznToCU = {1'($urandom_range(0, 1)), z, 1'($urandom_range(0, 1))};
  endtask

  task automatic run_instr(input logic [7:0] ir, input logic z, input string tag);
    logic [W-1:0] e;
    int c;
    drive(ir, z);
    model(ir, z);
    c = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      check($sformatf("%s ir=%02h z=%0b cyc%0d", tag, ir, z, c), obs, e);
      @(posedge clk); #1;
      c++;
    end
  endtask

  // Counts cycles until the next fetch, remembering the last cycle's outputs.
  task automatic run_count(input logic [7:0] ir, input logic z, input int exp_cyc,
                           input logic [W-1:0] exp_last);
    int n;
    logic done;
    logic [W-1:0] last;
    drive(ir, z);
    @(negedge clk);
    last = obs;
    n = 1;
    done = 1'b0;
    while (!done && n < 10) begin
      @(posedge clk); #1;
      if (obs[3]) done = 1'b1;
      else begin
        last = obs;
        n++;
      end
    end
    check_int($sformatf("cpi ir=%02h z=%0b", ir, z), n, exp_cyc);
    check($sformatf("last ir=%02h z=%0b", ir, z), last, exp_last);
    if (!done) begin
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
    end
  endtask

  typedef struct {
    logic [7:0]   ir;
    logic         z;
    int           cycles;
    logic [W-1:0] last;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs.push_back('{8'h05, 1'b0, 6, B_ACCW});
    vecs.push_back('{8'h3A, 1'b1, 6, B_MEMWR});
    vecs.push_back('{8'h45, 1'b0, 4, B_PCLD});
    vecs.push_back('{8'h60, 1'b1, 4, B_PCLD});
    vecs.push_back('{8'h60, 1'b0, 3, W_F2});
    vecs.push_back('{8'h86, 1'b0, 6, B_ACCW | A_DST});
    vecs.push_back('{8'hB7, 1'b1, 6, B_ACCW | A_DST});
    vecs.push_back('{8'hC0, 1'b0, 2, B_DI});
    vecs.push_back('{8'hEF, 1'b1, 2, B_DI});
    vecs.push_back('{8'hF3, 1'b0, 2, B_DI});
`ifndef CONTROL_UNIT_HLT_EN
    vecs.push_back('{8'hD0, 1'b0, 2, B_DI});
`endif

    // reset held 3 cycles with IR=0x2A
    rst = 1'b0;
    drive(8'h2A, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset cyc%0d", i), obs, '0);
    end
    @(posedge clk); #1;
    rst = 1'b1;

    // directed instruction sequences
    run_instr(8'h05, 1'b0, "ldm");
    run_instr(8'h86, 1'b0, "radd");
    run_instr(8'h60, 1'b1, "bz_taken");
    run_instr(8'h60, 1'b0, "bz_untaken");

    foreach (vecs[i]) run_count(vecs[i].ir, vecs[i].z, vecs[i].cycles, vecs[i].last);

    // reset asserted while an STM sits in SALU
    drive(8'h25, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("stm abort cyc%0d", i), obs, '0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    run_instr(8'hC0, 1'b0, "after_abort");

`ifdef CONTROL_UNIT_HLT_EN
    drive(8'hD0, 1'b0);
    @(negedge clk);
    check("hlt fetch", obs, W_F1);
    @(posedge clk); #1;
    @(negedge clk);
    check("hlt decode", obs, B_DI);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("halted cyc%0d", i), obs, B_HALTED);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("halt reset", obs, '0);
    @(posedge clk); #1;
    rst = 1'b1;
    run_instr(8'hC0, 1'b0, "after_halt");
`else
    run_instr(8'hD0, 1'b0, "hlt_as_nop");
`endif

    // randomized instruction stream against the reference model
    for (int i = 0; i < 300; i++) begin
      logic [7:0] ir;
      ir = 8'($urandom_range(0, 255));
`ifdef CONTROL_UNIT_HLT_EN
      if (ir[7:4] == 4'hD) ir = 8'hC0;
`endif
      run_instr(ir, 1'($urandom_range(0, 1)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multicycle control FSM for the 8-bit accumulator CPU: the consuming end of the datapath's status interface (`DiToCU`, `IrToCU`, `CznToCU`) and the producer of every datapath control strobe. It sequences fetch, decode, memory-reference, register-ALU and branch instructions over 2–6 cycles each. It instantiates alongside `Datapath` in the CPU top and shares its `clk` and `rst`.

## Interface
- No parameters.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `DiToCU` in 5: latched IR[4:0].
- `IrToCU` in 4: IR[7:4] (opcode field).
- `CznToCU` in 3: flags; [0]=C, [1]=Z, [2]=N.
- Outputs, each 1 bit: `pcInc`, `pcLoadEn`, `diLoadEn`, `irWriteEn`, `trWriteEn`, `memoryReadEn`, `memoryWriteEn`, `accumulatorWriteEn`, `aRegWriteEn`, `bRegWriteEn`, `aluResWriteEn`, `ldCZN`, `PcOrTR`, `regOrMem`, `RegAOr0`, `RegBOr0`.
- Mux select meanings: `PcOrTR` 1=PC, 0=TR. `regOrMem` 1=acc, 0=mem. `RegAOr0`/`RegBOr0` 1=zero.
- `accAddressSel` out 2: 00=DI[4:3], 01=IR[1:0] (src), 10=IR[3:2] (dst).
- `aluOpControl` out 2: 00 ADD, 01 ADC, 10 AND, 11 NOT(B).
- `halted` out 1: core stopped (only with CU_HLT_EN).

## Operation
- Moore FSM. Every output is a pure decode of state plus the latched IR; unlisted outputs are 0 in each state.
- ISA:
  - IR[7]=0: two-byte memory reference. IR[6:5]: 00 LDM, 01 STM, 10 JMP, 11 BZ. Address = {IR[4:0], byte2}. Accumulator index = DI[4:3].
  - IR[7:6]=10: register ALU op. IR[5:4] is the ALU op. dst=IR[3:2], src=IR[1:0]. Result goes to acc[dst].
  - IR[7:4]=1100: NOP. 1101: HLT. 1110 and 1111 are treated as NOP.
- States and strobes:
  - FETCH1: PcOrTR=1, memoryReadEn, irWriteEn, pcInc. → DECODE.
  - DECODE: diLoadEn. Memory class → FETCH2. Register class → RRD_A. NOP → FETCH1. HLT → HALT.
  - FETCH2: PcOrTR=1, memoryReadEn, trWriteEn, pcInc. LDM → MRD. STM → SRD. JMP → JUMP. BZ → JUMP if Z=1, else FETCH1.
  - MRD: PcOrTR=0, memoryReadEn, regOrMem=0, bRegWriteEn. → MALU.
  - MALU: RegAOr0=1, op=00, aluResWriteEn, ldCZN. → WB.
  - SRD: accAddressSel=00, regOrMem=1, bRegWriteEn. → SALU.
  - SALU: RegAOr0=1, op=00, aluResWriteEn. ldCZN=0. → SWR.
  - SWR: PcOrTR=0, memoryWriteEn. → FETCH1.
  - JUMP: pcLoadEn. → FETCH1.
  - RRD_A: accAddressSel=10, aRegWriteEn. → RRD_B.
  - RRD_B: accAddressSel=01, regOrMem=1, bRegWriteEn. → RALU.
  - RALU: op=IR[5:4], aluResWriteEn, ldCZN. → WB.
  - WB: accumulatorWriteEn. accAddressSel=00 for memory class, 10 for register class. → FETCH1.
  - HALT: all strobes 0, `halted`=1. Only `rst` exits this state.
- The Z test for BZ samples `CznToCU[1]` in FETCH2. The flags reflect the last ldCZN instruction.

## Timing
- Reset: while `rst`=0 on a rising edge, state←FETCH1. During reset every output is forced 0, including `halted`. The first fetch occurs on the first cycle with `rst`=1.
- Reset mid-instruction aborts it with no further strobes. A partially executed STM never writes memory unless SWR was already reached.
- Cycles per instruction: NOP 2; JMP and taken BZ 4; untaken BZ 3; LDM, STM and register ops 6.
- Memory read is combinational. Read data is captured at the end of the strobing state.
- `pcInc` and `pcLoadEn` are never asserted together. `memoryReadEn` and `memoryWriteEn` are never asserted together.

## Configuration
- `CONTROL_UNIT_HLT_EN` defined: the HALT state and the HLT decode exist. `halted` behaves as described above.
- Not defined: 1101 decodes as NOP (DECODE → FETCH1). `halted` is tied 0 and there is no HALT state.

## Structure
- `cpu_pkg`: state enum, opcode constants (LDM/STM/JMP/BZ, class codes, NOP/HLT), ALU op encodings, accAddressSel encodings, flag bit indices.
- One sub-module, `control_decode`: combinational state+IR → strobe decode. The state register and next-state logic stay in `control_unit`.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with IR=0x2A → all outputs 0. Release → FETCH1 strobes (memoryReadEn, irWriteEn, pcInc, PcOrTR=1) on the first cycle.
- LDM: IR=0x05 (acc idx DI[4:3]=00) → exact 6-cycle strobe sequence FETCH1..WB. accAddressSel=00 in WB; ldCZN only in MALU.
- Register ADD: IR=0x86 (dst=01, src=10) → accAddressSel 10, 01, then 10 in WB. aluOpControl=00 in RALU.
- BZ: IR=0x60 with Z=1 → pcLoadEn in cycle 4. With Z=0 → back in FETCH1 in cycle 4, pcLoadEn never asserted.
- HLT: IR=0xD0 → `halted`=1 and zero strobes for 20 cycles, then `rst` pulse → FETCH1. Without the macro: 2-cycle NOP.
- Reset asserted in SALU of an STM → memoryWriteEn never asserted; FETCH1 follows release.
